// File: rtl/memrx_pkg.sv
// rtl/memrx_pkg.sv - shared receiver state encoding and default sizing constants
package memrx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam int DEFAULT_CLOCKS_PER_BAUD = 868;
  localparam int DEFAULT_MSGLEN          = 1600;
  localparam int DEFAULT_AW              = 11;

endpackage

// File: rtl/rxuart_core.sv
// rtl/rxuart_core.sv - 8N1 bit-level receiver: synchroniser, baud/bit timing, frame FSM
module rxuart_core
  import memrx_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic       o_stb,
  output logic [7:0] o_data,
  output logic       o_frame_err
);

  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLOCKS_PER_BAUD / 2 - 1);

  logic            rx_m_q, rx_s_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            stb_q, stb_d;
  logic [7:0]      data_q, data_d;
  logic            ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    stb_d   = 1'b0;
    data_d  = data_q;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          baud_d  = HALF_BIT;
          state_d = START;
        end
      end
      START: begin
        if (baud_q != '0) begin
          baud_d = baud_q - CW'(1);
        end else if (rx_s_q) begin
          // Line back high at mid start bit: treat as noise, not an error
          state_d = IDLE;
        end else begin
          baud_d  = FULL_BIT;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_q != '0) begin
          baud_d = baud_q - CW'(1);
        end else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          baud_d  = FULL_BIT;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (baud_q != '0) begin
          baud_d = baud_q - CW'(1);
        end else if (rx_s_q) begin
          stb_d   = 1'b1;
          data_d  = shift_q;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = BREAK;
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      stb_q   <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      rx_m_q  <= i_uart_rx;
      rx_s_q  <= rx_m_q;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_stb       = stb_q;
  assign o_data      = data_q;
  assign o_frame_err = ferr_q;

endmodule

// File: rtl/memrx.sv
// rtl/memrx.sv - UART message capture into a 2^AW byte buffer with registered read port
module memrx
  import memrx_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
  parameter int MSGLEN          = DEFAULT_MSGLEN,
  parameter int AW              = DEFAULT_AW
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_uart_rx,
  input  logic          i_restart,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic [AW-1:0] o_wr_index,
  output logic          o_rx_stb,
  output logic [7:0]    o_rx_data,
  output logic          o_done,
  output logic          o_frame_err
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(MSGLEN - 1);

  logic          core_stb;
  logic [7:0]    core_data;
  logic          core_ferr;
  logic [AW-1:0] wr_index_q, wr_index_d;
  logic [7:0]    rd_data_q;
  logic [7:0]    mem_q [0:DEPTH-1];

  rxuart_core #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_core (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_uart_rx   (i_uart_rx),
    .o_stb       (core_stb),
    .o_data      (core_data),
    .o_frame_err (core_ferr)
  );

  // The byte lands in memory on the edge that ends the strobe cycle,
  // so a coincident restart still writes at the old index.
  always_comb begin
    wr_index_d = wr_index_q;
    if (i_restart)
      wr_index_d = '0;
    else if (core_stb)
      wr_index_d = (wr_index_q == LAST_IDX) ? '0 : wr_index_q + AW'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) wr_index_q <= '0;
    else            wr_index_q <= wr_index_d;
  end

  always_ff @(posedge i_clk) begin
    if (core_stb) mem_q[wr_index_q] <= core_data;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rd_data_q <= '0;
    else            rd_data_q <= mem_q[i_rd_addr];
  end

  assign o_rd_data   = rd_data_q;
  assign o_wr_index  = wr_index_q;
  assign o_rx_stb    = core_stb;
  assign o_rx_data   = core_data;
  assign o_done      = core_stb & (wr_index_q == LAST_IDX) & ~i_restart;
  assign o_frame_err = core_ferr;

endmodule

// File: doc/memrx.md
Name: memrx

Overview:
- UART receive counterpart to the message transmitter: deserialises 8N1 frames from a serial line and stores each good byte into an internal 2048-byte buffer at an auto-incrementing write index.
- Completes one message after MSGLEN bytes and pulses a done flag.
- A registered random-access read port lets the FPGA top level or a bench read back the captured message.
- Sits as a top-level test block alongside the transmitter, needing only the clock and RX pin.

Parameters:
- CLOCKS_PER_BAUD, 868, clocks per bit period (100 MHz / 115200); must be at least 4.
- MSGLEN, 1600, bytes per message; range 1..2048.
- AW, 11, buffer address width (buffer depth 2^AW).

Ports:
- i_clk  input  1  system clock.
- i_reset_n  input  1  reset, asynchronous assert, active-low.
- i_uart_rx  input  1  asynchronous serial line, idle high.
- i_restart  input  1  synchronous pulse: restart message capture at index 0.
- i_rd_addr  input  AW  buffer read address.
- o_rd_data  output  8  buffer contents at i_rd_addr, one cycle later.
- o_wr_index  output  AW  next buffer address to be written.
- o_rx_stb  output  1  one-cycle pulse: good byte stored.
- o_rx_data  output  8  last good byte, valid with o_rx_stb.
- o_done  output  1  one-cycle pulse: byte MSGLEN-1 stored.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset, async on i_reset_n low:
  - FSM in IDLE.
  - Synchroniser flops set to 1.
  - Baud counter and bit counter cleared.
  - o_wr_index = 0.
  - o_rx_stb, o_done and o_frame_err = 0.
  - o_rx_data = 0, o_rd_data = 0.
  - Buffer contents are not reset.
- Input path: two-flop synchroniser on i_uart_rx. All decisions use the second flop (rx_s); total input latency is 2 clocks.
- FSM states:
  - IDLE: on rx_s == 0, load baud counter with CLOCKS_PER_BAUD/2 - 1 and go to START.
  - START: at counter 0, sample rx_s. If 1 (glitch/false start), go to IDLE with no error. If 0, load CLOCKS_PER_BAUD - 1, clear the bit count and go to DATA.
  - DATA: at each counter 0, shift rx_s into the shift register MSB-first-in, so the byte is LSB-first on the wire. Reload the counter. After the 8th bit, go to STOP.
  - STOP: at counter 0, sample rx_s.
    - If 1: write the byte to buffer[o_wr_index], pulse o_rx_stb, register o_rx_data, go to IDLE.
    - If 0: pulse o_frame_err, discard the byte, leave the index unchanged, go to BREAK.
  - BREAK: wait for rx_s == 1, then go to IDLE. A held-low line therefore produces exactly one o_frame_err.
- Timing:
  - Each sample point is at bit centre ±1 clock.
  - o_rx_stb occurs in the clock after the mid-stop-bit sample.
  - Back-to-back frames with zero idle are accepted, because IDLE is re-entered half a bit before the stop bit ends.
- Write index:
  - Increments by 1 on each good byte.
  - If the byte is written at index MSGLEN-1, o_done pulses together with o_rx_stb and the index wraps to 0.
  - The index never exceeds MSGLEN-1.
- i_restart:
  - Forces o_wr_index to 0 on the next clock.
  - Does not disturb the bit-level FSM.
  - If coincident with a good-byte write, the write still occurs at the old index, but restart wins on the index (result 0) and o_done is suppressed.
- Read port:
  - o_rd_data <= buffer[i_rd_addr] every clock, one cycle latency.
  - Read and write to the same address in the same cycle returns the old data (read-before-write). This is block-RAM inferable.
- All arithmetic is unsigned. Counters are sized by $clog2(CLOCKS_PER_BAUD).

Decomposition:
- Package memrx_pkg holds:
  - the FSM state enum: IDLE, START, DATA, STOP, BREAK;
  - the default CLOCKS_PER_BAUD constant;
  - the AW constant.
- Sub-module rxuart_core holds the bit-level receiver: synchroniser, baud/bit counters and FSM, with outputs stb, data and frame_err.
- memrx holds the buffer, write index, restart and done logic, and the read port.

Test Plan:
- Serial bytes 0x48, 0x69 at CLOCKS_PER_BAUD=16 -> two o_rx_stb pulses with o_rx_data 0x48 then 0x69; o_wr_index ends at 2; reading addr 0 and 1 returns 0x48 and 0x69 one cycle later.
- MSGLEN=4; send 0x01..0x05 back-to-back with no idle -> o_done pulses with byte 0x04; index wraps to 0; buffer[0]=0x05.
- 3-clock low glitch on idle line -> no o_rx_stb, no o_frame_err, index unchanged.
- Frame 0xA5 with stop bit low, then line held low 40 bit-times -> exactly one o_frame_err; no write; index unchanged; next good 0x3C is stored at the old index.
- i_restart asserted in the same cycle as the o_rx_stb for a byte at index 2 -> buffer[2] written; o_wr_index = 0; no o_done.
- i_reset_n dropped mid-DATA, released, then 0x55 sent -> outputs zero during reset; 0x55 stored at index 0 with no spurious byte.
